// File: rtl/lsu_s2.sv
// Load/store response stage: tracks outstanding memory requests in order and
// formats returned load data (byte/half/word, sign or zero extension) into a one-entry result buffer.
module lsu_s2 #(
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [1:0]  req_off,
  output logic        req_ready,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  input  logic        flush,
  output logic        res_valid,
  output logic [31:0] res_data,
  input  logic        res_ready,
  output logic        resp_err,
  output logic [1:0]  outstanding
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  logic             r_wr     [QDEPTH];
  logic [1:0]       r_size   [QDEPTH];
  logic             r_uns    [QDEPTH];
  logic [1:0]       r_off    [QDEPTH];
  logic             r_killed [QDEPTH];

  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             r_res_valid;
  logic [31:0]      r_res_data;
  logic             r_resp_err;

  logic [CW:0]      w_occ;
  logic             w_push;
  logic             w_pop;
  logic             w_load;
  logic [1:0]       w_size;
  logic             w_uns;
  logic [1:0]       w_off;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_fmt;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Counting the held result keeps a landing slot for every outstanding response.
  assign w_occ     = {1'b0, r_count} + (CW+1)'(r_res_valid);
  assign req_ready = w_occ < (CW+1)'(QDEPTH);

  assign w_push = req_valid & req_ready;
  assign w_pop  = data_data_ok & (r_count != '0);
  assign w_load = w_pop & ~r_wr[r_head] & ~r_killed[r_head];

  assign w_size = r_size[r_head];
  assign w_uns  = r_uns[r_head];
  assign w_off  = r_off[r_head];
  assign w_byte = data_rdata[{w_off, 3'b000} +: 8];
  assign w_half = data_rdata[{w_off[1], 4'b0000} +: 16];

  always_comb begin
    w_fmt = data_rdata;
    case (w_size)
      2'd0:    w_fmt = {{24{w_byte[7] & ~w_uns}}, w_byte};
      2'd1:    w_fmt = {{16{w_half[15] & ~w_uns}}, w_half};
      default: w_fmt = data_rdata;
    endcase
  end

  // Entry storage needs no reset: occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (flush) begin
      for (int i = 0; i < QDEPTH; i++) r_killed[i] <= 1'b1;
    end
    if (w_push) begin
      r_wr[r_tail]     <= req_wr;
      r_size[r_tail]   <= req_size;
      r_uns[r_tail]    <= req_unsigned;
      r_off[r_tail]    <= req_off;
      r_killed[r_tail] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      r_resp_err <= data_data_ok & (r_count == '0);
      if (w_push) r_tail <= f_inc(r_tail);
      if (w_pop)  r_head <= f_inc(r_head);
      if (w_push & ~w_pop)      r_count <= r_count + CW'(1);
      else if (~w_push & w_pop) r_count <= r_count - CW'(1);
      if (flush) begin
        r_res_valid <= 1'b0;
      end else if (w_load) begin
        r_res_valid <= 1'b1;
        r_res_data  <= w_fmt;
      end else if (res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign resp_err    = r_resp_err;
  assign outstanding = 2'(r_count);

endmodule

// File: tb/tb_lsu_s2.sv
// Scoreboard bench for lsu_s2: queue-based reference model of requests and results,
// directed scenarios followed by a randomized run.
module tb_lsu_s2;

  localparam int QD = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [1:0]  req_off;
  logic        req_ready;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        flush;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ready;
  logic        resp_err;
  logic [1:0]  outstanding;

  lsu_s2 #(.QDEPTH(QD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_off(req_off), .req_ready(req_ready),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .flush(flush),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .resp_err(resp_err), .outstanding(outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       wr;
    bit [1:0] sz;
    bit       un;
    bit [1:0] off;
    bit       killed;
  } ent_t;

  ent_t        pend[$];
  logic [31:0] sb[$];
  bit          m_err;
  bit          mon_en;
  int          n_chk;
  int          n_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmt(input bit [1:0] sz, input bit un, input bit [1:0] off,
                                      input logic [31:0] d);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (d >> (8 * off)) & 32'h0000_00FF;
      if (!un && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (d >> (16 * (off / 2))) & 32'h0000_FFFF;
      if (!un && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  // Reference model: in-order request list plus the list of results awaiting writeback.
  always @(posedge clk) begin
    ent_t        e;
    ent_t        n;
    bit          got;
    logic [31:0] val;
    if (rst) begin
      pend.delete();
      sb.delete();
      m_err = 0;
    end else begin
      m_err = data_data_ok && (pend.size() == 0);
      got   = 0;
      val   = '0;
      if (data_data_ok && pend.size() != 0) begin
        e = pend.pop_front();
        if (!e.wr && !e.killed) begin
          got = 1;
          val = fmt(e.sz, e.un, e.off, data_rdata);
        end
      end
      if (flush) begin
        foreach (pend[i]) pend[i].killed = 1;
        sb.delete();
      end else if (got) begin
        sb.delete();
        sb.push_back(val);
      end
      if (req_valid) begin
        n.wr = req_wr; n.sz = req_size; n.un = req_unsigned; n.off = req_off; n.killed = 0;
        pend.push_back(n);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("outstanding", 32'(outstanding), pend.size());
      chk("req_ready", 32'(req_ready), 32'((pend.size() + sb.size()) < QD));
      chk("resp_err", 32'(resp_err), 32'(m_err));
      chk("res_valid", 32'(res_valid), 32'(sb.size() != 0));
      if (res_valid && sb.size() != 0) begin
        chk("res_data", res_data, sb[0]);
        if (res_ready && !flush && !rst) void'(sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit wr, input bit [1:0] sz, input bit un, input bit [1:0] off);
    req_valid = 1; req_wr = wr; req_size = sz; req_unsigned = un; req_off = off;
    step();
    req_valid = 0;
  endtask

  task automatic respond(input logic [31:0] d);
    data_data_ok = 1; data_rdata = d;
    step();
    data_data_ok = 0;
  endtask

  task automatic load_check(input string nm, input bit [1:0] sz, input bit un, input bit [1:0] off,
                            input logic [31:0] d, input logic [31:0] exp);
    res_ready = 0;
    push(0, sz, un, off);
    respond(d);
    chk({nm, "_valid"}, 32'(res_valid), 32'd1);
    chk({nm, "_data"}, res_data, exp);
    res_ready = 1;
    step();
    res_ready = 0;
  endtask

  initial begin
    n_chk = 0; n_err = 0; mon_en = 0;
    rst = 1; req_valid = 0; req_wr = 0; req_size = 0; req_unsigned = 0; req_off = 0;
    data_data_ok = 0; data_rdata = 0; flush = 0; res_ready = 0;
    step();
    mon_en = 1;
    step();
    rst = 0;
    step();
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);

    load_check("byte_s_off3", 2'd0, 0, 2'd3, 32'h80AB_CD12, 32'hFFFF_FF80);
    load_check("byte_u_off3", 2'd0, 1, 2'd3, 32'h80AB_CD12, 32'h0000_0080);
    load_check("byte_s_off1", 2'd0, 0, 2'd1, 32'h80AB_CD12, 32'hFFFF_FFCD);
    load_check("half_s_off2", 2'd1, 0, 2'd2, 32'h7FFF_8000, 32'h0000_7FFF);
    load_check("half_s_off0", 2'd1, 0, 2'd0, 32'h7FFF_8000, 32'hFFFF_8000);
    load_check("half_u_off0", 2'd1, 1, 2'd0, 32'h7FFF_8000, 32'h0000_8000);
    load_check("word_u", 2'd2, 1, 2'd1, 32'h8765_4321, 32'h8765_4321);
    load_check("word_sz3", 2'd3, 0, 2'd0, 32'hF00D_CAFE, 32'hF00D_CAFE);

    // Two loads with writeback stalled: back-pressure through the held result.
    res_ready = 0;
    push(0, 2'd2, 0, 2'd0);
    push(0, 2'd2, 0, 2'd0);
    chk("bp_ready_full", 32'(req_ready), 32'd0);
    chk("bp_outstanding", 32'(outstanding), 32'd2);
    respond(32'h1111_1111);
    chk("bp_valid", 32'(res_valid), 32'd1);
    chk("bp_ready_held", 32'(req_ready), 32'd0);
    res_ready = 1;
    step();
    chk("bp_ready_free", 32'(req_ready), 32'd1);
    respond(32'h2222_2222);
    chk("bp_data2", res_data, 32'h2222_2222);
    step();
    res_ready = 0;

    // Store response drains the queue without producing a result.
    push(1, 2'd2, 0, 2'd0);
    chk("st_out1", 32'(outstanding), 32'd1);
    respond(32'hDEAD_BEEF);
    chk("st_out0", 32'(outstanding), 32'd0);
    chk("st_valid", 32'(res_valid), 32'd0);

    // Flush kills older loads; a load pushed alongside a flush survives.
    res_ready = 1;
    push(0, 2'd2, 0, 2'd0);
    push(0, 2'd2, 0, 2'd0);
    flush = 1;
    step();
    flush = 0;
    chk("fl_outstanding", 32'(outstanding), 32'd2);
    respond(32'hAAAA_0001);
    chk("fl_drop1", 32'(res_valid), 32'd0);
    flush = 1;
    push(0, 2'd2, 0, 2'd0);
    flush = 0;
    respond(32'hAAAA_0002);
    chk("fl_drop2", 32'(res_valid), 32'd0);
    respond(32'h1234_5678);
    chk("fl_third_valid", 32'(res_valid), 32'd1);
    chk("fl_third_data", res_data, 32'h1234_5678);
    step();

    // Spurious response with nothing outstanding.
    respond(32'h5555_5555);
    chk("err_pulse", 32'(resp_err), 32'd1);
    chk("err_no_valid", 32'(res_valid), 32'd0);
    step();
    chk("err_clear", 32'(resp_err), 32'd0);

    // Reset with two requests in flight drops them.
    push(0, 2'd2, 0, 2'd0);
    push(0, 2'd2, 0, 2'd0);
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_out", 32'(outstanding), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    respond(32'h0BAD_F00D);
    chk("mid_rst_err", 32'(resp_err), 32'd1);
    chk("mid_rst_valid", 32'(res_valid), 32'd0);

    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 299) == 0);
      flush        = ($urandom_range(0, 24) == 0);
      req_valid    = ((pend.size() + sb.size()) < QD) && ($urandom_range(0, 1) == 1);
      req_wr       = ($urandom_range(0, 3) == 0);
      req_size     = 2'($urandom_range(0, 3));
      req_unsigned = 1'($urandom_range(0, 1));
      req_off      = 2'($urandom_range(0, 3));
      data_data_ok = (pend.size() != 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      data_rdata   = $urandom;
      res_ready    = ($urandom_range(0, 9) < 7);
      step();
    end

    rst = 0; flush = 0; req_valid = 0; data_data_ok = 0; res_ready = 1;
    step();
    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lsu_s2.md
LSU_S2 -- requirements
Module: lsu_s2

Interface
REQ-001 SHALL have parameter QDEPTH, default 2, number of outstanding memory requests tracked.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port req_valid, input, 1, request accepted by memory this cycle (upstream data_req && data_addr_ok).
REQ-005 SHALL have port req_wr, input, 1, accepted request is store/sc (no result data).
REQ-006 SHALL have port req_size, input, 2, access size: 0 byte, 1 half, 2 word; 3 treated as word.
REQ-007 SHALL have port req_unsigned, input, 1, zero-extend load result.
REQ-008 SHALL have port req_off, input, 2, target address bits [1:0].
REQ-009 SHALL have port req_ready, output, 1, stage can accept another request; upstream SHALL NOT assert req_valid while low.
REQ-010 SHALL have port data_data_ok, input, 1, memory returns one response this cycle (in request order).
REQ-011 SHALL have port data_rdata, input, 32, response word.
REQ-012 SHALL have port flush, input, 1, pipeline cancel (exception/eret/change).
REQ-013 SHALL have port res_valid, output, 1, formatted load result held.
REQ-014 SHALL have port res_data, output, 32, formatted load result.
REQ-015 SHALL have port res_ready, input, 1, writeback consumes result.
REQ-016 SHALL have port resp_err, output, 1, one-cycle pulse: response arrived with empty queue.
REQ-017 SHALL have port outstanding, output, 2, current queue occupancy.

Function
REQ-018 SHALL hold a FIFO of QDEPTH entries {wr, size, unsigned, off, killed}, with head/tail pointers wrapping modulo QDEPTH and occupancy counter.
REQ-019 SHALL push an entry on req_valid with killed=0; push in same cycle as flush SHALL NOT be killed (flush applies to older entries only).
REQ-020 SHALL pop head on data_data_ok when occupancy>0; simultaneous push and pop SHALL leave occupancy unchanged.
REQ-021 SHALL assert req_ready = (occupancy + res_valid) < QDEPTH, combinationally, guaranteeing every response has a landing slot.
REQ-022 On pop of an entry with wr=0 and killed=0, SHALL load res_data next cycle and set res_valid; latency response-to-res_valid exactly 1 cycle.
REQ-023 On pop of an entry with wr=1 or killed=1, SHALL discard data; res_valid unaffected.
REQ-024 Byte: res_data = rdata[8*off+7:8*off], sign- or zero-extended to 32 bits.
REQ-025 Half: res_data = rdata[16*off[1]+15:16*off[1]] extended; off[0] ignored (alignment checked upstream).
REQ-026 Word: res_data = rdata unchanged; req_unsigned ignored.
REQ-027 res_valid SHALL clear on res_ready when no new result loads that cycle; simultaneous consume and new result SHALL keep res_valid=1 with new data.
REQ-028 flush SHALL set killed on all queued entries and clear res_valid the next cycle, overriding a same-cycle result load; occupancy unchanged (responses still drained).
REQ-029 data_data_ok with occupancy 0 SHALL be ignored and pulse resp_err for one cycle.
REQ-030 outstanding SHALL equal occupancy register.

Reset
REQ-031 While rst high at a clock edge: occupancy=0, pointers=0, res_valid=0, res_data=0, resp_err=0; req_ready=1 after reset.
REQ-032 rst mid-operation SHALL drop all entries and results; a later response SHALL produce resp_err, not res_valid.

Verification
REQ-033 Load byte signed, off=3, rdata=0x80AB_CD12 -> res_valid next cycle, res_data=0xFFFF_FF80; unsigned -> 0x0000_0080.
REQ-034 Load half signed, off=2, rdata=0x7FFF_8000 -> res_data=0x0000_7FFF; off=0 -> 0xFFFF_8000.
REQ-035 Two loads pushed back-to-back, res_ready=0 -> req_ready low after second push; first response -> res_valid, req_ready stays low; res_ready=1 -> req_ready high.
REQ-036 Store pushed, response 0xDEAD_BEEF -> outstanding 1->0, res_valid stays 0.
REQ-037 Two loads outstanding, flush with new load pushed same cycle -> first two responses discarded, third delivers its word.
REQ-038 data_data_ok with outstanding=0 -> resp_err=1 for one cycle, res_valid=0; rst asserted with outstanding=2 -> outstanding=0, req_ready=1.
